// File: rtl/width_down_conv.sv
// width_down_conv: serialises one IN_W-bit word into RATIO beats of OUT_W
// bits with valid/ready handshakes on both sides. A word can be loaded on
// the same edge that its predecessor's final beat leaves, so a steady
// stream sustains one beat per cycle with no bubble between words.
module width_down_conv #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [IN_W-1:0]   data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              last_out,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_word;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_ready_in;
  logic               w_valid_out;
  logic               w_is_last;
  logic               w_accept;
  logic               w_beat_xfer;
  logic [OUT_W-1:0]   w_beat;
  logic [IN_W-1:0]    w_word_shifted;

  // The current beat always sits at one end of the shift register; the
  // register shifts toward that end after each transferred beat.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_beat         = r_word[IN_W-1 -: OUT_W];
    assign w_word_shifted = r_word << OUT_W;
  end else begin : g_lsb_first
    assign w_beat         = r_word[OUT_W-1:0];
    assign w_word_shifted = r_word >> OUT_W;
  end

  assign w_is_last = (r_idx == LAST_IDX);

  // Next-state and handshake outputs; reset forces every output low.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the case/if leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_ready_in  = 1'b0;
    w_valid_out = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_in = 1'b1;
        if (valid_in) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_valid_out = 1'b1;
        // Room for a new word only as the final beat leaves.
        w_ready_in  = w_is_last && ready_out;
        if (w_is_last && ready_out && !valid_in) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) begin
      w_state_nxt = IDLE;
      w_ready_in  = 1'b0;
      w_valid_out = 1'b0;
    end
  end

  assign w_accept    = valid_in && w_ready_in;
  assign w_beat_xfer = w_valid_out && ready_out;

  // State register.
  always_ff @(posedge clk_4f) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register and beat index: load on accept, advance on each beat.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_word <= data_in;
      r_idx  <= '0;
    end else if (w_beat_xfer) begin
      if (w_is_last) begin
        // Word finished with nothing behind it: drain to zero for IDLE.
        r_word <= '0;
        r_idx  <= '0;
      end else begin
        r_word <= w_word_shifted;
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  // Completed-word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_beat_xfer && w_is_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ready_in  = w_ready_in;
  assign valid_out = w_valid_out;
  assign data_out  = w_valid_out ? w_beat : '0;
  assign last_out  = w_valid_out && w_is_last;
  assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_width_down_conv.sv
// tb_width_down_conv: scenario tasks drive two converters (default 32->8
// MSB-first, and 64->16 LSB-first with a 2-bit counter); a negedge monitor
// keeps per-DUT scoreboards of expected beats pushed at each accept.
module tb_width_down_conv;

  logic        clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_out;
  logic        last_out;
  logic [15:0] word_cnt;

  logic [63:0] data_in_b;
  logic        valid_in_b;
  logic        ready_in_b;
  logic [15:0] data_out_b;
  logic        valid_out_b;
  logic        ready_out_b;
  logic        last_out_b;
  logic [1:0]  word_cnt_b;

  width_down_conv dut_a (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out),
    .word_cnt  (word_cnt)
  );

  width_down_conv #(
    .IN_W      (64),
    .OUT_W     (16),
    .MSB_FIRST (0),
    .CNT_W     (2)
  ) dut_b (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in_b),
    .valid_in  (valid_in_b),
    .ready_in  (ready_in_b),
    .data_out  (data_out_b),
    .valid_out (valid_out_b),
    .ready_out (ready_out_b),
    .last_out  (last_out_b),
    .word_cnt  (word_cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic [8:0]  q_a[$];   // {last, beat}
  logic [16:0] q_b[$];

  function automatic logic [7:0] beat_a(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (24 - 8 * k);
    return t[7:0];
  endfunction

  function automatic logic [15:0] beat_b(input logic [63:0] w, input int k);
    logic [63:0] t;
    t = w >> (16 * k);
    return t[15:0];
  endfunction

  // Scoreboard monitor: compare each transferred beat, then queue the beats
  // of any word accepted at the coming edge. Reset discards pending beats.
  always @(negedge clk_4f) begin
    logic [8:0]  ea;
    logic [16:0] eb;
    if (reset) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (valid_out && ready_out) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_extra: got beat %h last %b, required no beat", data_out, last_out);
        end else begin
          ea = q_a.pop_front();
          if ({last_out, data_out} !== ea) begin
            n_fail++;
            $display("FAIL sb_a_beat: got %h last %b, required %h last %b", data_out, last_out, ea[7:0], ea[8]);
          end
        end
      end
      if (valid_out_b && ready_out_b) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_extra: got beat %h last %b, required no beat", data_out_b, last_out_b);
        end else begin
          eb = q_b.pop_front();
          if ({last_out_b, data_out_b} !== eb) begin
            n_fail++;
            $display("FAIL sb_b_beat: got %h last %b, required %h last %b", data_out_b, last_out_b, eb[15:0], eb[16]);
          end
        end
      end
      if (valid_in && ready_in) begin
        for (int k = 0; k < 4; k++) q_a.push_back({(k == 3), beat_a(data_in, k)});
      end
      if (valid_in_b && ready_in_b) begin
        for (int k = 0; k < 4; k++) q_b.push_back({(k == 3), beat_b(data_in_b, k)});
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    ready_out = 1'b1;
    repeat (2) @(posedge clk_4f);
    #1;
    @(negedge clk_4f);
    n_checks++;
    if (ready_in !== 1'b0) begin n_fail++; $display("FAIL rst_ready_in: got %b, required 0", ready_in); end
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out: got %b, required 0", valid_out); end
    n_checks++;
    if (last_out !== 1'b0) begin n_fail++; $display("FAIL rst_last_out: got %b, required 0", last_out); end
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h, required 00", data_out); end
    n_checks++;
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_word_cnt: got %0d, required 0", word_cnt); end
    n_checks++;
    if (word_cnt_b !== 2'd0) begin n_fail++; $display("FAIL rst_word_cnt_b: got %0d, required 0", word_cnt_b); end
    valid_in = 1'b0;
    next_cycle();
  endtask

  // One word, accepted on the first edge after reset drops.
  task automatic test_single;
    logic [7:0] exp_b [4] = '{8'hFF, 8'hFB, 8'hBF, 8'hFF};
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hFFFB_BFFF;
    @(negedge clk_4f);
    n_checks++;
    if (ready_in !== 1'b1) begin n_fail++; $display("FAIL single_ready_in: got %b, required 1", ready_in); end
    next_cycle();
    valid_in = 1'b0;
    data_in  = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4f);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== exp_b[k] || last_out !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v%b %h l%b, required v1 %h l%b", k, valid_out, data_out, last_out, exp_b[k], (k == 3));
      end
      next_cycle();
    end
    exp_cnt = 1;
    @(negedge clk_4f);
    n_checks++;
    if (valid_out !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL single_end: got valid %b cnt %0d, required valid 0 cnt %0d", valid_out, word_cnt, exp_cnt);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic exp_rdy;
    for (int c = 0; c < 10; c++) begin
      valid_in = (c <= 4);
      data_in  = (c == 0) ? 32'hFFFB_BFFF : 32'hDDDD_DDDD;
      @(negedge clk_4f);
      if (c < 9) begin
        exp_rdy = (c == 0) || (c == 4) || (c == 8);
        n_checks++;
        if (ready_in !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready_in c%0d: got %b, required %b", c, ready_in, exp_rdy); end
        n_checks++;
        if (valid_out !== (c != 0)) begin n_fail++; $display("FAIL b2b_valid_out c%0d: got %b, required %b", c, valid_out, (c != 0)); end
      end else begin
        exp_cnt += 2;
        n_checks++;
        if (valid_out !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL b2b_end: got valid %b cnt %0d, required valid 0 cnt %0d", valid_out, word_cnt, exp_cnt);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_ignore_invalid;
    logic [7:0] exp_b [4] = '{8'h00, 8'h00, 8'h00, 8'h03};
    for (int c = 0; c < 8; c++) begin
      valid_in = (c == 2);
      data_in  = (c == 2) ? 32'h0000_0003 : 32'hAAAA_AAAA;
      @(negedge clk_4f);
      if (c < 3) begin
        n_checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
          n_fail++;
          $display("FAIL ign_idle c%0d: got valid %b ready %b, required valid 0 ready 1", c, valid_out, ready_in);
        end
      end else if (c < 7) begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== exp_b[c-3]) begin
          n_fail++;
          $display("FAIL ign_beat%0d: got v%b %h, required v1 %h", c - 3, valid_out, data_out, exp_b[c-3]);
        end
      end else begin
        exp_cnt += 1;
        n_checks++;
        if (valid_out !== 1'b0 || word_cnt !== 16'(exp_cnt) || q_a.size() != 0) begin
          n_fail++;
          $display("FAIL ign_end: got valid %b cnt %0d pending %0d, required 0 %0d 0", valid_out, word_cnt, q_a.size(), exp_cnt);
        end
      end
      next_cycle();
    end
  endtask

  // Stall on beat 1 and on the final beat, with the next word waiting.
  task automatic test_stall;
    for (int c = 0; c < 14; c++) begin
      ready_out = !((c >= 2 && c <= 4) || c == 7);
      valid_in  = (c == 0) || (c >= 2 && c <= 8);
      data_in   = (c == 0) ? 32'h1122_3344 : 32'h5566_7788;
      @(negedge clk_4f);
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (data_out !== 8'h22 || ready_in !== 1'b0 || valid_out !== 1'b1 || last_out !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_b1 c%0d: got %h rdy %b v %b l %b, required 22 0 1 0", c, data_out, ready_in, valid_out, last_out);
        end
      end else if (c == 6) begin
        n_checks++;
        if (data_out !== 8'h33) begin n_fail++; $display("FAIL stall_resume: got %h, required 33", data_out); end
      end else if (c == 7) begin
        n_checks++;
        if (data_out !== 8'h44 || last_out !== 1'b1 || ready_in !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_last: got %h l %b rdy %b, required 44 1 0", data_out, last_out, ready_in);
        end
      end else if (c == 8) begin
        n_checks++;
        if (ready_in !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got ready %b, required 1", ready_in); end
      end else if (c == 13) begin
        exp_cnt += 2;
        n_checks++;
        if (valid_out !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL stall_end: got valid %b cnt %0d, required valid 0 cnt %0d", valid_out, word_cnt, exp_cnt);
        end
      end
      next_cycle();
    end
    ready_out = 1'b1;
    valid_in  = 1'b0;
  endtask

  // LSB-first 64->16, five words back-to-back through a 2-bit counter.
  task automatic test_lsb_wrap;
    logic [63:0] words [5];
    logic [15:0] exp_b [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    logic [1:0]  exp_wc [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int          wi;
    words[0] = 64'h0123_4567_89AB_CDEF;
    for (int i = 1; i < 5; i++) words[i] = {$urandom(), $urandom()};
    wi = 0;
    ready_out_b = 1'b1;
    for (int c = 0; c < 22; c++) begin
      valid_in_b = (wi < 5);
      data_in_b  = (wi < 5) ? words[wi] : 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk_4f);
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (data_out_b !== exp_b[c-1] || last_out_b !== (c == 4)) begin
          n_fail++;
          $display("FAIL lsb_beat%0d: got %h l %b, required %h l %b", c - 1, data_out_b, last_out_b, exp_b[c-1], (c == 4));
        end
      end
      if (c >= 5 && (c - 1) % 4 == 0) begin
        n_checks++;
        if (word_cnt_b !== exp_wc[(c-5)/4]) begin
          n_fail++;
          $display("FAIL lsb_word_cnt c%0d: got %0d, required %0d", c, word_cnt_b, exp_wc[(c-5)/4]);
        end
      end
      if (valid_in_b && ready_in_b) wi++;
      next_cycle();
    end
    valid_in_b = 1'b0;
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int c = 0; c < 10; c++) begin
      reset    = (c == 3);
      valid_in = (c == 0) || (c == 4);
      data_in  = (c == 0) ? 32'hDEAD_BEEF : 32'h0102_0304;
      @(negedge clk_4f);
      if (c == 2) begin
        n_checks++;
        if (data_out !== 8'hAD) begin n_fail++; $display("FAIL rmid_beat1: got %h, required AD", data_out); end
      end else if (c == 3) begin
        n_checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b0 || data_out !== 8'h00) begin
          n_fail++;
          $display("FAIL rmid_during: got v %b rdy %b %h, required 0 0 00", valid_out, ready_in, data_out);
        end
      end else if (c == 4) begin
        exp_cnt = 0;
        n_checks++;
        if (valid_out !== 1'b0 || word_cnt !== 16'd0 || ready_in !== 1'b1) begin
          n_fail++;
          $display("FAIL rmid_after: got v %b cnt %0d rdy %b, required 0 0 1", valid_out, word_cnt, ready_in);
        end
      end else if (c >= 5 && c <= 8) begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== exp_b[c-5]) begin
          n_fail++;
          $display("FAIL rmid_new_beat%0d: got v%b %h, required v1 %h", c - 5, valid_out, data_out, exp_b[c-5]);
        end
      end else if (c == 9) begin
        exp_cnt = 1;
        n_checks++;
        if (valid_out !== 1'b0 || word_cnt !== 16'(exp_cnt)) begin
          n_fail++;
          $display("FAIL rmid_end: got valid %b cnt %0d, required valid 0 cnt %0d", valid_out, word_cnt, exp_cnt);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    reset       = 1'b1;
    data_in     = '0;
    valid_in    = 1'b0;
    ready_out   = 1'b1;
    data_in_b   = '0;
    valid_in_b  = 1'b0;
    ready_out_b = 1'b1;

    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_invalid();
    test_stall();
    test_lsb_wrap();
    test_reset_mid_word();

    @(negedge clk_4f);
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/width_down_conv.md
WIDTH_DOWN_CONV -- requirements
Module: width_down_conv

Interface
REQ-001 The module SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 The module SHALL have parameter OUT_W, default 8, output beat width in bits; IN_W SHALL be an integer multiple of OUT_W, with RATIO = IN_W/OUT_W >= 2.
REQ-003 The module SHALL have parameter MSB_FIRST, default 1; 1 = most-significant slice sent first, 0 = least-significant first.
REQ-004 The module SHALL have parameter CNT_W, default 16, width of the completed-word counter.
REQ-005 clk_4f  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  IN_W  parallel input word.
REQ-008 valid_in  input  1  data_in holds a word to be accepted.
REQ-009 ready_in  output  1  converter accepts data_in this cycle.
REQ-010 data_out  output  OUT_W  current serial beat.
REQ-011 valid_out  output  1  data_out holds a valid beat.
REQ-012 ready_out  input  1  downstream accepts data_out this cycle.
REQ-013 last_out  output  1  current beat is the final slice of its word.
REQ-014 word_cnt  output  CNT_W  number of words fully sent since reset.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word held, beats pending).
REQ-016 Input accept SHALL occur when valid_in && ready_in; the handshake is evaluated on the clock edge.
REQ-017 ready_in SHALL be 1 in IDLE, and 1 in SHIFT only when beat index == RATIO-1 && ready_out == 1; it SHALL be 0 otherwise.
REQ-018 On accept, the word SHALL load into the shift register, the beat index SHALL be set to 0, and the FSM SHALL enter SHIFT on the next cycle.
REQ-019 Latency SHALL be one cycle: the first beat of an accepted word is on data_out with valid_out=1 in the cycle after the accept.
REQ-020 valid_out SHALL equal (state == SHIFT).
REQ-021 With MSB_FIRST=1, beat k SHALL be word[IN_W-1-k*OUT_W -: OUT_W]; with MSB_FIRST=0, beat k SHALL be word[k*OUT_W +: OUT_W].
REQ-022 A beat transfer SHALL occur when valid_out && ready_out; the beat index SHALL then increment by 1.
REQ-023 While ready_out == 0 in SHIFT, data_out, last_out and the beat index SHALL hold unchanged.
REQ-024 last_out SHALL be 1 exactly when state == SHIFT and beat index == RATIO-1.
REQ-025 On a transfer of the last beat, word_cnt SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-026 On a transfer of the last beat, if valid_in == 1 the next word SHALL be loaded and SHIFT retained (back-to-back, no bubble); otherwise the FSM SHALL return to IDLE.
REQ-027 In IDLE, data_out SHALL be 0 and last_out SHALL be 0.
REQ-028 When valid_in == 0, data_in SHALL be ignored; a word presented with valid_in == 0 is never sent.
REQ-029 Sustained throughput SHALL be one beat per cycle when valid_in and ready_out stay high.

Reset
REQ-030 When reset == 1 at a clock edge, the FSM SHALL go to IDLE, the beat index and shift register SHALL clear to 0, and word_cnt SHALL clear to 0.
REQ-031 During reset, ready_in, valid_out, last_out and data_out SHALL all be 0.
REQ-032 Reset asserted mid-word SHALL discard the remaining beats of that word, and word_cnt SHALL not count that word.
REQ-033 The first accept SHALL be possible on the first edge after reset deasserts.

Verification
REQ-034 Defaults; one word 32'hFFFBBFFF with ready_out=1 -> beats FF, FB, BF, FF on 4 consecutive cycles starting 1 cycle after accept; last_out on the 4th beat; word_cnt=1.
REQ-035 Back-to-back 32'hFFFBBFFF then 32'hDDDDDDDD, valid_in held -> 8 contiguous beats with no gap; ready_in high only on the beat-3 cycle; word_cnt=2.
REQ-036 valid_in=0 with data_in=32'hAAAAAAAA, then valid_in=1 with 32'h00000003 -> no AA beat appears; beats are 00,00,00,03.
REQ-037 ready_out held low for 3 cycles during beat 1 of 32'h11223344 -> data_out stays 22 and ready_in stays 0; the sequence resumes with 33 after release.
REQ-038 MSB_FIRST=0, IN_W=64, OUT_W=16, word 64'h0123456789ABCDEF -> beats CDEF, 89AB, 4567, 0123.
REQ-039 Reset pulsed after beat 1 of 32'hDEADBEEF -> next cycle valid_out=0 and word_cnt=0; a following word 32'h01020304 is sent intact.
